// File: rtl/wb_arbiter_pkg.sv
// Shared widths, register-file constants and grant encoding for the writeback arbiter.
package wb_arbiter_pkg;

    localparam int RADDR_WIDTH   = 5;
    localparam int RDATA_WIDTH   = 32;
    localparam int WB_STARVE_MAX = 4;
    localparam int STARVE_CNT_W  = 4;

    localparam logic [RADDR_WIDTH-1:0] ZERO_REG     = '0;
    localparam logic                   WRITE_ENABLE = 1'b1;

    typedef enum logic [1:0] {
        GRANT_IDLE = 2'd0,
        GRANT_PIPE = 2'd1,
        GRANT_MDU  = 2'd2
    } grant_e;

endpackage

// File: rtl/wb_mdu_buf.sv
// One-entry holding buffer for MDU results. It accepts only when empty, so a drain
// and a refill can never land on the same edge.
module wb_mdu_buf
    import wb_arbiter_pkg::*;
#(
    parameter int AW = RADDR_WIDTH,
    parameter int DW = RDATA_WIDTH
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load_valid,
    input  logic [AW-1:0] i_load_addr,
    input  logic [DW-1:0] i_load_data,
    input  logic          i_drain,
    input  logic          i_drop,
    output logic          o_ready,
    output logic          o_valid,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_data
);

    logic          r_valid;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          w_load;

    assign o_ready = !i_rst && !r_valid;
    assign w_load  = i_load_valid && o_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
        end else if (i_drain || i_drop) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr <= '0;
            r_data <= '0;
        end else if (w_load) begin
            r_addr <= i_load_addr;
            r_data <= i_load_data;
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;
    assign o_data  = r_data;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges MEM/WB and MDU results onto one regfile write port.
// Optional perf counters are enabled with `define WB_PERF_EN.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = WB_STARVE_MAX,
    parameter int AW         = RADDR_WIDTH,
    parameter int DW         = RDATA_WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          pipe_valid_i,
    input  logic          pipe_we_i,
    input  logic [AW-1:0] pipe_waddr_i,
    input  logic [DW-1:0] pipe_wdata_i,
    output logic          pipe_ready_o,
    input  logic          mdu_valid_i,
    input  logic [AW-1:0] mdu_waddr_i,
    input  logic [DW-1:0] mdu_wdata_i,
    output logic          mdu_ready_o,
    output logic          we_o,
    output logic [AW-1:0] waddr_o,
    output logic [DW-1:0] wdata_o
`ifdef WB_PERF_EN
    ,
    output logic [31:0]   perf_pipe_wr_o,
    output logic [31:0]   perf_mdu_wr_o,
    output logic [31:0]   perf_stall_o,
    output logic [31:0]   perf_drop_o
`endif
);

    localparam logic [AW-1:0]           ZERO_ADDR = AW'(ZERO_REG);
    localparam logic [STARVE_CNT_W-1:0] CNT_MAX   = STARVE_CNT_W'(STARVE_MAX);

    logic                    w_buf_v;
    logic                    w_buf_ready;
    logic [AW-1:0]           w_buf_addr;
    logic [DW-1:0]           w_buf_data;
    logic                    w_force;
    logic                    w_drop;
    logic                    w_pipe_we;
    logic                    w_mdu_we;
    grant_e                  w_grant;

    logic                    r_we;
    logic [AW-1:0]           r_waddr;
    logic [DW-1:0]           r_wdata;
    logic [STARVE_CNT_W-1:0] r_starve_cnt;

    wb_mdu_buf #(
        .AW (AW),
        .DW (DW)
    ) u_mdu_buf (
        .i_clk        (clk_i),
        .i_rst        (rst_i),
        .i_load_valid (mdu_valid_i),
        .i_load_addr  (mdu_waddr_i),
        .i_load_data  (mdu_wdata_i),
        .i_drain      (w_grant == GRANT_MDU),
        .i_drop       (w_drop),
        .o_ready      (w_buf_ready),
        .o_valid      (w_buf_v),
        .o_addr       (w_buf_addr),
        .o_data       (w_buf_data)
    );

    // A buffered MDU result that has lost STARVE_MAX times in a row stalls the pipe once.
    assign w_force      = w_buf_v && (r_starve_cnt == CNT_MAX);
    assign pipe_ready_o = !rst_i && !w_force;
    assign mdu_ready_o  = w_buf_ready;

    always_comb begin
        w_grant = GRANT_IDLE;
        if (pipe_valid_i && pipe_ready_o) begin
            w_grant = GRANT_PIPE;
        end else if (w_buf_v && !rst_i) begin
            w_grant = GRANT_MDU;
        end
    end

    assign w_pipe_we = pipe_we_i && (pipe_waddr_i != ZERO_ADDR);
    assign w_mdu_we  = (w_buf_addr != ZERO_ADDR);

    // Younger pipeline write to the same rd makes the older buffered MDU result dead.
    assign w_drop = (w_grant == GRANT_PIPE) && pipe_we_i && w_buf_v &&
                    (pipe_waddr_i == w_buf_addr) && (w_buf_addr != ZERO_ADDR);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            unique case (w_grant)
                GRANT_PIPE: begin
                    r_we    <= w_pipe_we ? WRITE_ENABLE : !WRITE_ENABLE;
                    r_waddr <= pipe_waddr_i;
                    r_wdata <= pipe_wdata_i;
                end
                GRANT_MDU: begin
                    r_we    <= w_mdu_we ? WRITE_ENABLE : !WRITE_ENABLE;
                    r_waddr <= w_buf_addr;
                    r_wdata <= w_buf_data;
                end
                default: begin
                    r_we <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !w_buf_v || (w_grant == GRANT_MDU)) begin
            r_starve_cnt <= '0;
        end else if ((w_grant == GRANT_PIPE) && (r_starve_cnt != CNT_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign we_o    = r_we;
    assign waddr_o = r_waddr;
    assign wdata_o = r_wdata;

`ifdef WB_PERF_EN
    logic [31:0] r_perf_pipe_wr;
    logic [31:0] r_perf_mdu_wr;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_drop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_pipe_wr <= '0;
            r_perf_mdu_wr  <= '0;
            r_perf_stall   <= '0;
            r_perf_drop    <= '0;
        end else begin
            if ((w_grant == GRANT_PIPE) && w_pipe_we) begin
                r_perf_pipe_wr <= r_perf_pipe_wr + 32'd1;
            end
            if ((w_grant == GRANT_MDU) && w_mdu_we) begin
                r_perf_mdu_wr <= r_perf_mdu_wr + 32'd1;
            end
            if (pipe_valid_i && !pipe_ready_o) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_drop) begin
                r_perf_drop <= r_perf_drop + 32'd1;
            end
        end
    end

    assign perf_pipe_wr_o = r_perf_pipe_wr;
    assign perf_mdu_wr_o  = r_perf_mdu_wr;
    assign perf_stall_o   = r_perf_stall;
    assign perf_drop_o    = r_perf_drop;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic against a
// queue-based reference model of the writeback rules.
`timescale 1ns/1ps
module tb_wb_arbiter;

    localparam int SM = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          pipe_valid;
    logic          pipe_we;
    logic [AW-1:0] pipe_waddr;
    logic [DW-1:0] pipe_wdata;
    logic          pipe_ready;
    logic          mdu_valid;
    logic [AW-1:0] mdu_waddr;
    logic [DW-1:0] mdu_wdata;
    logic          mdu_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
`ifdef WB_PERF_EN
    logic [31:0]   perf_pipe_wr;
    logic [31:0]   perf_mdu_wr;
    logic [31:0]   perf_stall;
    logic [31:0]   perf_drop;
`endif

    always #5 clk = ~clk;

    wb_arbiter #(
        .STARVE_MAX (SM),
        .AW         (AW),
        .DW         (DW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .pipe_valid_i (pipe_valid),
        .pipe_we_i    (pipe_we),
        .pipe_waddr_i (pipe_waddr),
        .pipe_wdata_i (pipe_wdata),
        .pipe_ready_o (pipe_ready),
        .mdu_valid_i  (mdu_valid),
        .mdu_waddr_i  (mdu_waddr),
        .mdu_wdata_i  (mdu_wdata),
        .mdu_ready_o  (mdu_ready),
        .we_o         (we),
        .waddr_o      (waddr),
        .wdata_o      (wdata)
`ifdef WB_PERF_EN
        ,
        .perf_pipe_wr_o (perf_pipe_wr),
        .perf_mdu_wr_o  (perf_mdu_wr),
        .perf_stall_o   (perf_stall),
        .perf_drop_o    (perf_drop)
`endif
    );

    // Reference model state: the MDU buffer is a queue of at most one entry.
    wr_t           mbuf[$];
    int            m_cnt;
    logic          m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    int            m_pipe_wr, m_mdu_wr, m_stall, m_drop;
    logic [AW+DW-1:0] exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic m_pipe_ready();
        return !rst && !((mbuf.size() != 0) && (m_cnt == SM));
    endfunction

    function automatic logic m_mdu_ready();
        return !rst && (mbuf.size() == 0);
    endfunction

    task automatic drive(input logic pv, input logic pwe, input logic [AW-1:0] pa,
                         input logic [DW-1:0] pd, input logic mv,
                         input logic [AW-1:0] ma, input logic [DW-1:0] md);
        pipe_valid = pv; pipe_we = pwe; pipe_waddr = pa; pipe_wdata = pd;
        mdu_valid = mv; mdu_waddr = ma; mdu_wdata = md;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Advance the model by one clock from the current inputs, then cross the edge.
    task automatic step();
        logic pr, mr, pg, mg, dr;
        wr_t  e;
        pr = m_pipe_ready();
        mr = m_mdu_ready();
        if (rst) begin
            mbuf.delete();
            m_cnt = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
            m_pipe_wr = 0; m_mdu_wr = 0; m_stall = 0; m_drop = 0;
        end else begin
            pg = pipe_valid && pr;
            mg = !pg && (mbuf.size() != 0);
            dr = pg && pipe_we && (mbuf.size() != 0) && (mbuf[0].addr == pipe_waddr) && (pipe_waddr != 0);
            if (pipe_valid && !pr) m_stall++;
            if (pg) begin
                m_we = pipe_we && (pipe_waddr != 0);
                m_waddr = pipe_waddr;
                m_wdata = pipe_wdata;
                if (m_we) m_pipe_wr++;
            end else if (mg) begin
                m_we = (mbuf[0].addr != 0);
                m_waddr = mbuf[0].addr;
                m_wdata = mbuf[0].data;
                if (m_we) m_mdu_wr++;
            end else begin
                m_we = 1'b0;
            end
            if (m_we) exp_q.push_back({m_waddr, m_wdata});
            if ((mbuf.size() == 0) || mg) m_cnt = 0;
            else if (pg && (m_cnt < SM)) m_cnt++;
            if (mg || dr) void'(mbuf.pop_front());
            if (dr) m_drop++;
            if (mdu_valid && mr) begin
                e.addr = mdu_waddr;
                e.data = mdu_wdata;
                mbuf.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        n_tests++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b expected 0", we); end
        n_tests++; if (waddr !== '0) begin n_fail++; $display("FAIL reset_waddr: got %0h expected 0", waddr); end
        n_tests++; if (wdata !== '0) begin n_fail++; $display("FAIL reset_wdata: got %0h expected 0", wdata); end
        n_tests++; if (pipe_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pipe_ready: got %0b expected 0", pipe_ready); end
        n_tests++; if (mdu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mdu_ready: got %0b expected 0", mdu_ready); end
        rst = 1'b0;
        #1;
        n_tests++; if (pipe_ready !== 1'b1) begin n_fail++; $display("FAIL release_pipe_ready: got %0b expected 1", pipe_ready); end
        n_tests++; if (mdu_ready !== 1'b1) begin n_fail++; $display("FAIL release_mdu_ready: got %0b expected 1", mdu_ready); end
    endtask

    task automatic test_pipe_write();
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        step();
        n_tests++; if (we !== 1'b1) begin n_fail++; $display("FAIL pipe_we: got %0b expected 1", we); end
        n_tests++; if (waddr !== 5'd5) begin n_fail++; $display("FAIL pipe_waddr: got %0d expected 5", waddr); end
        n_tests++; if (wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pipe_wdata: got %0h expected deadbeef", wdata); end
        idle();
        step();
        n_tests++; if (we !== 1'b0) begin n_fail++; $display("FAIL pipe_idle_we: got %0b expected 0", we); end
        n_tests++; if (waddr !== 5'd5) begin n_fail++; $display("FAIL pipe_idle_hold: got %0d expected 5", waddr); end
    endtask

    task automatic test_mdu_write();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 32'h12);
        n_tests++; if (mdu_ready !== 1'b1) begin n_fail++; $display("FAIL mdu_ready_empty: got %0b expected 1", mdu_ready); end
        step();
        idle();
        n_tests++; if (mdu_ready !== 1'b0) begin n_fail++; $display("FAIL mdu_ready_full: got %0b expected 0", mdu_ready); end
        n_tests++; if (we !== 1'b0) begin n_fail++; $display("FAIL mdu_latency_we: got %0b expected 0", we); end
        step();
        n_tests++; if (we !== 1'b1) begin n_fail++; $display("FAIL mdu_we: got %0b expected 1", we); end
        n_tests++; if (waddr !== 5'd7) begin n_fail++; $display("FAIL mdu_waddr: got %0d expected 7", waddr); end
        n_tests++; if (wdata !== 32'h12) begin n_fail++; $display("FAIL mdu_wdata: got %0h expected 12", wdata); end
        n_tests++; if (mdu_ready !== 1'b1) begin n_fail++; $display("FAIL mdu_ready_drained: got %0b expected 1", mdu_ready); end
    endtask

    task automatic test_starvation();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd20, 32'h55);
        step();
        for (int i = 0; i < SM; i++) begin
            drive(1'b1, 1'b1, AW'(i + 1), 32'h100 + i, 1'b0, '0, '0);
            n_tests++; if (pipe_ready !== 1'b1) begin n_fail++; $display("FAIL starve_pipe_ready_%0d: got %0b expected 1", i, pipe_ready); end
            step();
            n_tests++; if (we !== 1'b1 || waddr !== AW'(i + 1)) begin n_fail++; $display("FAIL starve_pipe_wr_%0d: got we=%0b addr=%0d expected we=1 addr=%0d", i, we, waddr, i + 1); end
        end
        drive(1'b1, 1'b1, 5'd10, 32'h200, 1'b0, '0, '0);
        n_tests++; if (pipe_ready !== 1'b0) begin n_fail++; $display("FAIL starve_force: got pipe_ready=%0b expected 0", pipe_ready); end
        step();
        n_tests++; if (we !== 1'b1 || waddr !== 5'd20 || wdata !== 32'h55) begin n_fail++; $display("FAIL starve_mdu_wr: got we=%0b addr=%0d data=%0h expected 1/20/55", we, waddr, wdata); end
        n_tests++; if (pipe_ready !== 1'b1) begin n_fail++; $display("FAIL starve_resume: got pipe_ready=%0b expected 1", pipe_ready); end
        step();
        n_tests++; if (we !== 1'b1 || waddr !== 5'd10 || wdata !== 32'h200) begin n_fail++; $display("FAIL starve_pipe_after: got we=%0b addr=%0d data=%0h expected 1/10/200", we, waddr, wdata); end
        idle();
        step();
    endtask

    task automatic test_zero_reg();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'h33);
        step();
        drive(1'b1, 1'b1, 5'd0, 32'h44, 1'b0, '0, '0);
        n_tests++; if (pipe_ready !== 1'b1) begin n_fail++; $display("FAIL x0_pipe_ready: got %0b expected 1", pipe_ready); end
        step();
        n_tests++; if (we !== 1'b0) begin n_fail++; $display("FAIL x0_pipe_we: got %0b expected 0", we); end
        idle();
        step();
        n_tests++; if (we !== 1'b0) begin n_fail++; $display("FAIL x0_mdu_we: got %0b expected 0", we); end
        n_tests++; if (mdu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_mdu_consumed: got mdu_ready=%0b expected 1", mdu_ready); end
    endtask

    task automatic test_waw();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 32'h77);
        step();
        drive(1'b1, 1'b1, 5'd9, 32'hAA, 1'b0, '0, '0);
        step();
        n_tests++; if (we !== 1'b1 || waddr !== 5'd9 || wdata !== 32'hAA) begin n_fail++; $display("FAIL waw_pipe_wr: got we=%0b addr=%0d data=%0h expected 1/9/aa", we, waddr, wdata); end
        idle();
        n_tests++; if (mdu_ready !== 1'b1) begin n_fail++; $display("FAIL waw_buf_cleared: got mdu_ready=%0b expected 1", mdu_ready); end
        step();
        n_tests++; if (we !== 1'b0) begin n_fail++; $display("FAIL waw_no_mdu_wr: got we=%0b expected 0", we); end
`ifdef WB_PERF_EN
        n_tests++; if (perf_drop !== 32'd1) begin n_fail++; $display("FAIL waw_perf_drop: got %0d expected 1", perf_drop); end
        n_tests++; if (perf_pipe_wr !== 32'(m_pipe_wr)) begin n_fail++; $display("FAIL perf_pipe_wr: got %0d expected %0d", perf_pipe_wr, m_pipe_wr); end
        n_tests++; if (perf_mdu_wr !== 32'(m_mdu_wr)) begin n_fail++; $display("FAIL perf_mdu_wr: got %0d expected %0d", perf_mdu_wr, m_mdu_wr); end
        n_tests++; if (perf_stall !== 32'(m_stall)) begin n_fail++; $display("FAIL perf_stall: got %0d expected %0d", perf_stall, m_stall); end
`endif
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 32'h99);
        step();
        rst = 1'b1;
        drive(1'b1, 1'b1, 5'd4, 32'h88, 1'b0, '0, '0);
        step();
        n_tests++; if (we !== 1'b0) begin n_fail++; $display("FAIL rstmid_we: got %0b expected 0", we); end
        n_tests++; if (pipe_ready !== 1'b0 || mdu_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got pipe=%0b mdu=%0b expected 0/0", pipe_ready, mdu_ready); end
        step();
        rst = 1'b0;
        idle();
        n_tests++; if (mdu_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_mdu_ready: got %0b expected 1", mdu_ready); end
        step();
        n_tests++; if (we !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale: got we=%0b expected 0", we); end
    endtask

    task automatic test_random();
        logic [AW+DW-1:0] got;
        exp_q.delete();
        for (int c = 0; c < 500; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0), AW'($urandom_range(0, 7)),
                  $urandom, ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)), $urandom);
            n_tests++; if (pipe_ready !== m_pipe_ready()) begin n_fail++; $display("FAIL rnd_pipe_ready c%0d: got %0b expected %0b", c, pipe_ready, m_pipe_ready()); end
            n_tests++; if (mdu_ready !== m_mdu_ready()) begin n_fail++; $display("FAIL rnd_mdu_ready c%0d: got %0b expected %0b", c, mdu_ready, m_mdu_ready()); end
            step();
            n_tests++; if (we !== m_we || waddr !== m_waddr || wdata !== m_wdata) begin n_fail++; $display("FAIL rnd_out c%0d: got %0b/%0d/%0h expected %0b/%0d/%0h", c, we, waddr, wdata, m_we, m_waddr, m_wdata); end
            if (we === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_sb_extra c%0d: got write %0d/%0h expected none", c, waddr, wdata);
                end else begin
                    got = exp_q.pop_front();
                    if ({waddr, wdata} !== got) begin n_fail++; $display("FAIL rnd_sb_order c%0d: got %0h expected %0h", c, {waddr, wdata}, got); end
                end
            end
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_sb_missing: got %0d left expected 0", exp_q.size()); end
`ifdef WB_PERF_EN
        n_tests++; if (perf_drop !== 32'(m_drop) || perf_stall !== 32'(m_stall)) begin n_fail++; $display("FAIL rnd_perf: got drop=%0d stall=%0d expected %0d/%0d", perf_drop, perf_stall, m_drop, m_stall); end
`endif
        rst = 1'b0;
        idle();
        step();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_pipe_write();
        test_mdu_write();
        test_starvation();
        test_zero_reg();
        test_waw();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
